sqrt2_host: RTL and testbench

//  Bus-master sequencer for the sqrt2 unit's shared-bus protocol. Accepts FP16 operands on a valid/ready

---
 rtl/sqrt2_host.sv | 164 ++++++++++++++++
 tb/tb_sqrt2_host.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt2_host.sv
// Bus-master sequencer for the sqrt2 shared-bus protocol: queues FP16 operands, runs one
// ENABLE/IO_DATA transaction per operand and returns captured results in order.
`timescale 1ns/1ps
module sqrt2_host #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DRIVE_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_nan,
  output logic        rsp_pinf,
  output logic        rsp_ninf,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        enable,
  inout  wire  [15:0] io_data,
  input  logic        result,
  input  logic        is_nan,
  input  logic        is_pinf,
  input  logic        is_ninf
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned WW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SEQ_MAX = (DRIVE_CYCLES > GAP_CYCLES) ? DRIVE_CYCLES : GAP_CYCLES;
  localparam int unsigned SW      = $clog2(SEQ_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_HOLD, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic [15:0]     op, op_nxt;
  logic [SW-1:0]   seq_cnt, seq_cnt_nxt;
  logic [WW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            drive_en;
  logic            push, pop;
  logic            rsp_valid_nxt, rsp_nan_nxt, rsp_pinf_nxt, rsp_ninf_nxt, rsp_timeout_nxt;
  logic [15:0]     rsp_data_nxt;

  assign push    = req_valid && req_ready;
  assign io_data = drive_en ? op : 16'hzzzz;

  // Operand storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= req_data;
  end

  // Next-state, FIFO pop and response capture.
  always_comb begin
    state_nxt       = state;
    op_nxt          = op;
    seq_cnt_nxt     = seq_cnt;
    wait_cnt_nxt    = wait_cnt;
    pop             = 1'b0;
    rsp_valid_nxt   = rsp_valid && !rsp_ready;
    rsp_data_nxt    = rsp_data;
    rsp_nan_nxt     = rsp_nan;
    rsp_pinf_nxt    = rsp_pinf;
    rsp_ninf_nxt    = rsp_ninf;
    rsp_timeout_nxt = rsp_timeout;
    case (state)
      S_IDLE: begin
        if ((wr_ptr != rd_ptr) && (!rsp_valid || rsp_ready)) begin
          pop         = 1'b1;
          op_nxt      = fifo_mem[rd_ptr[AW-1:0]];
          seq_cnt_nxt = '0;
          state_nxt   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (seq_cnt == SW'(DRIVE_CYCLES - 1)) begin
          wait_cnt_nxt = '0;
          state_nxt    = S_WAIT;
        end else begin
          seq_cnt_nxt = seq_cnt + SW'(1);
        end
      end
      S_WAIT: begin
        if (result) begin
          rsp_valid_nxt   = 1'b1;
          rsp_data_nxt    = io_data;
          rsp_nan_nxt     = is_nan;
          rsp_pinf_nxt    = is_pinf;
          rsp_ninf_nxt    = is_ninf;
          rsp_timeout_nxt = 1'b0;
          state_nxt       = S_HOLD;
        end else if (wait_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_nxt   = 1'b1;
          rsp_data_nxt    = 16'h0000;
          rsp_nan_nxt     = 1'b0;
          rsp_pinf_nxt    = 1'b0;
          rsp_ninf_nxt    = 1'b0;
          rsp_timeout_nxt = 1'b1;
          wait_cnt_nxt    = WW'(TIMEOUT_CYCLES);
          state_nxt       = S_HOLD;
        end else if (wait_cnt != WW'(TIMEOUT_CYCLES)) begin
          wait_cnt_nxt = wait_cnt + WW'(1);
        end
      end
      S_HOLD: begin
        seq_cnt_nxt = '0;
        state_nxt   = S_GAP;
      end
      S_GAP: begin
        if (seq_cnt == SW'(GAP_CYCLES - 1)) state_nxt = S_IDLE;
        else seq_cnt_nxt = seq_cnt + SW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
    wr_ptr_nxt = wr_ptr + PW'(push);
    rd_ptr_nxt = rd_ptr + PW'(pop);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Status outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      op          <= '0;
      seq_cnt     <= '0;
      wait_cnt    <= '0;
      drive_en    <= 1'b0;
      enable      <= 1'b0;
      busy        <= 1'b0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_nan     <= 1'b0;
      rsp_pinf    <= 1'b0;
      rsp_ninf    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      op          <= op_nxt;
      seq_cnt     <= seq_cnt_nxt;
      wait_cnt    <= wait_cnt_nxt;
      drive_en    <= (state_nxt == S_DRIVE);
      enable      <= (state_nxt == S_DRIVE) || (state_nxt == S_WAIT) || (state_nxt == S_HOLD);
      busy        <= (state_nxt != S_IDLE) || (count_nxt != '0);
      req_ready   <= (count_nxt != PW'(FIFO_DEPTH));
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
      rsp_nan     <= rsp_nan_nxt;
      rsp_pinf    <= rsp_pinf_nxt;
      rsp_ninf    <= rsp_ninf_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_sqrt2_host.sv
// Bench for sqrt2_host: behavioural sqrt2 bus slave, scoreboard on the response port and
// a bus watcher checking drive window, ENABLE length and inter-operation gap.
`timescale 1ns/1ps
module tb_sqrt2_host;

  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_nan, rsp_pinf, rsp_ninf, rsp_timeout;
  logic        busy, enable;
  wire  [15:0] io_data;
  logic        result = 1'b0, is_nan = 1'b0, is_pinf = 1'b0, is_ninf = 1'b0;
  logic        slv_oe = 1'b0;
  logic [15:0] slv_data = '0;

  assign io_data = slv_oe ? slv_data : 16'hzzzz;

  sqrt2_host dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_nan(rsp_nan), .rsp_pinf(rsp_pinf), .rsp_ninf(rsp_ninf), .rsp_timeout(rsp_timeout),
    .busy(busy), .enable(enable), .io_data(io_data),
    .result(result), .is_nan(is_nan), .is_pinf(is_pinf), .is_ninf(is_ninf)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [19:0] exp_q[$];   // {timeout, nan, pinf, ninf, data}
  int          k_q[$];     // WAIT cycles each operation is expected to spend
  bit          no_result = 1'b0;
  int          ready_mode = 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Nobody drives the bus: reads as z in 4-state tools, 0 in 2-state ones (operand 0000 avoided).
  function automatic bit bus_free();
    return $isunknown(io_data) || (io_data === 16'h0000);
  endfunction

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  // FP16 square root from real arithmetic, round to nearest even.
  function automatic logic [19:0] ref_sqrt(input logic [15:0] x);
    int  e, m, ex, mi;
    real v, s, fr;
    e = int'(x[14:10]);
    m = int'(x[9:0]);
    if (e == 31 && m != 0) return {4'b0100, 16'hFE00};
    if (x[15] && (e != 0 || m != 0)) return {4'b0100, 16'hFE00};
    if (e == 31) return {4'b0010, 16'h7C00};
    if (e == 0 && m == 0) return {4'b0000, x};
    if (e == 0) v = $itor(m) * pow2(-24);
    else v = (1.0 + $itor(m) / 1024.0) * pow2(e - 15);
    s  = $sqrt(v);
    ex = 0;
    while (s >= 2.0) begin s = s / 2.0; ex++; end
    while (s < 1.0) begin s = s * 2.0; ex--; end
    fr = (s - 1.0) * 1024.0;
    mi = $rtoi(fr);
    fr = fr - $itor(mi);
    if (fr > 0.5 || (fr == 0.5 && mi[0])) mi++;
    if (mi == 1024) begin mi = 0; ex++; end
    return {4'b0000, 1'b0, 5'(ex + 15), 10'(mi)};
  endfunction

  // Consumer handshake driver.
  initial forever begin
    @(posedge clk); #1;
    rsp_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  // Behavioural sqrt2 slave on the shared bus.
  initial begin
    int          sst, cnt, d;
    logic [15:0] slv_op;
    logic [19:0] r;
    sst = 0; cnt = 0; slv_op = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        sst = 0; slv_oe = 1'b0; result = 1'b0;
        is_nan = 1'b0; is_pinf = 1'b0; is_ninf = 1'b0;
      end else begin
        case (sst)
          0: if (enable && !bus_free()) begin slv_op = io_data; sst = 1; end
          1: if (bus_free()) begin
               if (no_result) begin k_q.push_back(TIMEOUT); sst = 3; end
               else begin
                 d = $urandom_range(0, 4);
                 k_q.push_back(d + 1);
                 cnt = d;
                 sst = 2;
               end
             end
          3: if (!enable) sst = 0;
          4: begin
               slv_oe = 1'b0; result = 1'b0;
               is_nan = 1'b0; is_pinf = 1'b0; is_ninf = 1'b0;
               sst = 3;
             end
          default: ;
        endcase
        if (sst == 2) begin
          if (cnt == 0) begin
            r        = ref_sqrt(slv_op);
            slv_data = r[15:0];
            is_nan   = r[18];
            is_pinf  = r[17];
            is_ninf  = r[16];
            slv_oe   = 1'b1;
            result   = 1'b1;
            sst      = 4;
          end else cnt--;
        end
      end
    end
  end

  // Monitor: scoreboard on response handshakes plus bus/ENABLE timing.
  initial begin
    int   en_run, drv_run, low_run, k;
    bit   prev_en, host_drv;
    logic [19:0] e;
    en_run = 0; drv_run = 0; low_run = 99; prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_run = 0; drv_run = 0; low_run = 99; prev_en = 1'b0;
      end else begin
        host_drv = !bus_free() && !slv_oe;
        if (host_drv) chk("drive_window", 32'(enable && en_run < 2), 32'd1);
        if (enable) begin
          if (!prev_en) chk("enable_gap_ge2", 32'(low_run >= 2), 32'd1);
          en_run++;
          if (host_drv) drv_run++;
        end else begin
          if (prev_en) begin
            chk("drive_cycles", 32'(drv_run), 32'd2);
            if (k_q.size() == 0) chk("enable_no_k", 32'd1, 32'd0);
            else begin
              k = k_q.pop_front();
              chk("enable_cycles", 32'(en_run), 32'(2 + k + 1));
            end
            en_run = 0; drv_run = 0; low_run = 0;
          end
          low_run++;
        end
        prev_en = enable;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("rsp", 32'({rsp_timeout, rsp_nan, rsp_pinf, rsp_ninf, rsp_data}), 32'(e));
          end
        end
      end
    end
  end

  task automatic push_op(input logic [15:0] d, input logic [19:0] e, input bit track);
    int n = 0;
    req_valid = 1'b1;
    req_data  = d;
    @(negedge clk);
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("req_accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (track) exp_q.push_back(e);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy || rsp_valid) && n < 3000) begin @(negedge clk); n++; end
    chk("drain_timeout", 32'(n >= 3000), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          n;
    logic [31:0] rv;
    logic [15:0] x;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enable", 32'(enable), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_bus_free", 32'(bus_free()), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    ready_mode = 1;
    push_op(16'h3C00, {4'b0000, 16'h3C00}, 1'b1);
    drain();

    push_op(16'h7C00, {4'b0010, 16'h7C00}, 1'b1);
    push_op(16'hFC00, {4'b0100, 16'hFE00}, 1'b1);
    drain();

    push_op(16'h4400, {4'b0000, 16'h4000}, 1'b1);
    push_op(16'h4C00, {4'b0000, 16'h4400}, 1'b1);
    push_op(16'h5400, {4'b0000, 16'h4800}, 1'b1);
    drain();

    // Consumer stalled: one op completes, FIFO fills, no further bus activity.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    push_op(16'h4400, {4'b0000, 16'h4000}, 1'b1);
    push_op(16'h4C00, {4'b0000, 16'h4400}, 1'b1);
    push_op(16'h5400, {4'b0000, 16'h4800}, 1'b1);
    push_op(16'h3C00, {4'b0000, 16'h3C00}, 1'b1);
    push_op(16'h4000, {4'b0000, 16'h3DA8}, 1'b1);
    @(negedge clk);
    chk("stall_req_ready_full", 32'(req_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
    chk("stall_first_rsp", 32'(rsp_valid), 32'd1);
    repeat (10) @(negedge clk);
    chk("stall_enable_low", 32'(enable), 32'd0);
    chk("stall_rsp_held", 32'(rsp_valid), 32'd1);
    chk("stall_still_full", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    ready_mode = 1;
    drain();

    // Slave never answers: timeout response.
    no_result = 1'b1;
    push_op(16'h3C00, {4'b1000, 16'h0000}, 1'b1);
    drain();

    // Reset in the middle of WAIT: aborted silently.
    push_op(16'h4C00, 20'h0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!(enable && bus_free()) && n < 200) begin @(negedge clk); n++; end
    chk("reach_wait", 32'(enable && bus_free()), 32'd1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_enable", 32'(enable), 32'd0);
    chk("midreset_bus_free", 32'(bus_free()), 32'd1);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_q.delete();
    k_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    no_result = 1'b0;
    @(posedge clk); #1;
    push_op(16'h4000, {4'b0000, 16'h3DA8}, 1'b1);
    drain();

    // Random operands, random consumer back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      rv = $urandom();
      x  = rv[15:0];
      if (x == 16'h0000) x = 16'h0001;
      push_op(x, ref_sqrt(x), 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    ready_mode = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
